frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter MADDR_WIDTH, default 32: width of memory address ports.
REQ-002 Parameter STAGES, default 3, legal range 2..8: number of pipeline stages (fetch, vertex, pixel at default).
REQ-003 Parameter VERTEX_STRIDE, default 6: byte increment of the vertex address per triangle.
REQ-004 Parameter COLOR_STRIDE, default 2: byte increment of the color address per triangle.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-007 Port frame_start, input, 1: one-cycle frame request.
REQ-008 Port frame_abort, input, 1: abandon the current frame.
REQ-009 Port triangles_count, input, 32: number of triangles in the frame.
REQ-010 Port base_addr_vertex / base_addr_color, input, MADDR_WIDTH each: frame base addresses.
REQ-011 Port stage_eoc, input, STAGES: per-stage done level, bit 0 = first stage.
REQ-012 Port stage_start, output, STAGES: per-stage one-cycle start pulse.
REQ-013 Port advance, output, 1: enable for inter-stage data registers.
REQ-014 Port curr_addr_vertex / curr_addr_color, output, MADDR_WIDTH each: addresses of the triangle entering stage 0.
REQ-015 Port curr_triangle, output, 32: number of triangles issued in the current frame.
REQ-016 Ports busy, frame_done, overrun, irq (output, 1 each); irq_ack (input, 1).

Function
REQ-017 The FSM SHALL have states IDLE, ADVANCE, LAUNCH, WAIT, DONE.
REQ-018 IDLE: on frame_start SHALL latch triangles_count, both base addresses, clear curr_triangle and the valid vector, and go to ADVANCE.
REQ-019 ADVANCE: advance=1 for one cycle; valid <= {valid[STAGES-2:0], issue}, where issue = (curr_triangle < latched count).
REQ-020 On issue: curr_triangle SHALL increment; curr_addr SHALL load the base for the first triangle, else add the stride, wrapping modulo 2^MADDR_WIDTH.
REQ-021 ADVANCE exit: go to DONE if the new valid vector is zero, else go to LAUNCH.
REQ-022 LAUNCH: stage_start SHALL equal the valid vector for exactly one cycle, then go to WAIT.
REQ-023 WAIT: go to ADVANCE in the first cycle in which (stage_eoc | ~valid) is all ones; stage_eoc SHALL NOT be sampled in LAUNCH.
REQ-024 DONE: frame_done=1 for one cycle, then go to IDLE; a frame of N triangles takes N+STAGES advance cycles.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 frame_start while busy SHALL be ignored and set overrun (sticky); overrun clears on the next accepted frame_start.
REQ-027 frame_abort in any non-IDLE state SHALL go to IDLE next cycle, clear valid, and produce no frame_done; frame_abort has priority over every other transition.
REQ-028 triangles_count=0 SHALL go IDLE->ADVANCE->DONE with no stage_start pulse.

Reset
REQ-029 On reset_n low: state IDLE; valid, stage_start, advance, frame_done, busy, overrun, irq, curr_triangle, curr_addr_* all 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done.

Configuration
REQ-031 Macro FRAME_SEQ_IRQ_EN defined: irq SHALL set on frame_done and clear on irq_ack; on simultaneous set and ack, set wins.
REQ-032 Macro FRAME_SEQ_IRQ_EN undefined: irq is tied 0 and irq_ack is ignored.

Structure
REQ-033 Package frame_seq_pkg SHALL hold the state enum typedef and the STAGES legal-range constants.
REQ-034 Sub-module frame_seq_irq SHALL hold the irq latch; it is instantiated only under FRAME_SEQ_IRQ_EN.

Verification
REQ-035 Count=1, STAGES=3, stage_eoc tied 1 -> stage_start 001, 010, 100 on successive launches; 4 advance pulses; then frame_done.
REQ-036 Count=3, base_vertex=0x100, base_color=0x200 -> curr_addr_vertex 0x100/0x106/0x10C and curr_addr_color 0x200/0x202/0x204; curr_triangle ends at 3.
REQ-037 Count=0 -> frame_done 2 cycles after frame_start; stage_start never asserted.
REQ-038 Stage 1 eoc held low 10 cycles in WAIT -> no advance until it rises; advance one cycle after it rises.
REQ-039 frame_start during WAIT -> overrun=1 and frame unaffected; then frame_abort -> IDLE next cycle, no frame_done.
REQ-040 FRAME_SEQ_IRQ_EN defined, irq_ack in the frame_done cycle -> irq=1; ack one cycle later -> irq=0.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the frame sequencer.
// The STAGES bounds are the only pipeline depths the sequencer supports.
package frame_seq_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Stage control bus between the sequencer and the pipeline stages.
// The sequencer drives starts and advance; the stages return done levels.
interface frame_sequencer_if #(
    parameter int STAGES = 3
);
    logic [STAGES-1:0] stage_start;
    logic [STAGES-1:0] stage_eoc;
    logic              advance;

    modport master (
        output stage_start,
        output advance,
        input  stage_eoc
    );

    modport slave (
        input  stage_start,
        input  advance,
        output stage_eoc
    );
endinterface

// File: rtl/frame_sequencer_irq.sv
// Frame-complete interrupt latch; only built with FRAME_SEQ_IRQ_EN.
module frame_seq_irq
    import frame_seq_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic ack,
    output logic irq
);

    // A new completion must not be lost to an ack landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (set) begin
            irq <= 1'b1;
        end else if (ack) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: steps triangles through a STAGES-deep pipeline.
// Define FRAME_SEQ_IRQ_EN to build the frame-done interrupt latch.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int MADDR_WIDTH   = 32,
    parameter int STAGES        = 3,
    parameter int VERTEX_STRIDE = 6,
    parameter int COLOR_STRIDE  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic                   frame_abort,
    input  logic [31:0]            triangles_count,
    input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [MADDR_WIDTH-1:0] base_addr_color,
    frame_sequencer_if.master      stg,
    output logic [MADDR_WIDTH-1:0] curr_addr_vertex,
    output logic [MADDR_WIDTH-1:0] curr_addr_color,
    output logic [31:0]            curr_triangle,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   irq,
    input  logic                   irq_ack
);

    localparam logic [MADDR_WIDTH-1:0] V_STRIDE = MADDR_WIDTH'(VERTEX_STRIDE);
    localparam logic [MADDR_WIDTH-1:0] C_STRIDE = MADDR_WIDTH'(COLOR_STRIDE);

    state_t                 state_q;
    state_t                 state_d;
    logic [STAGES-1:0]      valid_q;
    logic [STAGES-1:0]      valid_d;
    logic [31:0]            count_q;
    logic [MADDR_WIDTH-1:0] base_v_q;
    logic [MADDR_WIDTH-1:0] base_c_q;
    logic                   issue;
    logic                   eoc_ok;
    logic                   abort_hit;
    logic                   accept;

    assign issue     = curr_triangle < count_q;
    assign valid_d   = {valid_q[STAGES-2:0], issue};
    assign eoc_ok    = &(stg.stage_eoc | ~valid_q);
    assign abort_hit = frame_abort && (state_q != S_IDLE);
    assign accept    = frame_start && (state_q == S_IDLE);

    assign busy            = state_q != S_IDLE;
    assign frame_done      = state_q == S_DONE;
    assign stg.advance     = state_q == S_ADVANCE;
    assign stg.stage_start = (state_q == S_LAUNCH) ? valid_q : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (frame_start) state_d = S_ADVANCE;
            S_ADVANCE: state_d = (valid_d == '0) ? S_DONE : S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;
            S_WAIT:    if (eoc_ok) state_d = S_ADVANCE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q          <= '0;
            count_q          <= '0;
            base_v_q         <= '0;
            base_c_q         <= '0;
            curr_triangle    <= '0;
            curr_addr_vertex <= '0;
            curr_addr_color  <= '0;
        end else if (abort_hit) begin
            valid_q <= '0;
        end else if (accept) begin
            valid_q       <= '0;
            count_q       <= triangles_count;
            base_v_q      <= base_addr_vertex;
            base_c_q      <= base_addr_color;
            curr_triangle <= '0;
        end else if (state_q == S_ADVANCE) begin
            valid_q <= valid_d;
            if (issue) begin
                curr_triangle <= curr_triangle + 32'd1;
                // First triangle loads the base; later ones step by stride.
                if (curr_triangle == '0) begin
                    curr_addr_vertex <= base_v_q;
                    curr_addr_color  <= base_c_q;
                end else begin
                    curr_addr_vertex <= curr_addr_vertex + V_STRIDE;
                    curr_addr_color  <= curr_addr_color + C_STRIDE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (accept) begin
            overrun <= 1'b0;
        end else if (frame_start) begin
            overrun <= 1'b1;
        end
    end

`ifdef FRAME_SEQ_IRQ_EN
    frame_seq_irq u_irq (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (frame_done),
        .ack     (irq_ack),
        .irq     (irq)
    );
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule
